fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 19-bit single-cycle CPU. Sits directly upstream of the 64-word instruction memory: owns the program counter, drives the memory's 6-bit word address, and captures the combinational read data into an instruction register. The instruction register is presented to decode through a valid/ready handshake. Redirects from execute (branch taken, jal) flush the held instruction and reload the PC.

## Interface
- `PC_W`, default 6: PC/address width in words; the address space is 2^PC_W entries.
- `INSTR_W`, default 19: instruction width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_addr` out PC_W: word address to instruction memory; equals the PC register.
- `imem_rd` in INSTR_W: combinational read data for `imem_addr`.
- `redirect_valid` in 1: load a new PC this cycle (branch/jump resolved).
- `redirect_pc` in PC_W: target PC when `redirect_valid`=1.
- `instr_valid` out 1: `instr` holds a fetched instruction.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `instr` out INSTR_W: fetched instruction.
- `instr_pc` out PC_W: address `instr` was fetched from.
- `instr_pc_plus1` out PC_W: `instr_pc`+1 modulo 2^PC_W (jal link value).
- `halted` out 1: fetch stopped on HALT (constant 0 without `FETCH_HALT_EN`).

## Operation
- Registers: `pc`, `instr`, `instr_pc`, `instr_valid`, and FSM state {RUN, HALT}.
- Reset (async, `rst_n`=0): `pc`=RESET_PC, `instr`=0, `instr_pc`=0, `instr_valid`=0, state=RUN, `halted`=0. The reset takes effect immediately, including mid-operation.
- Per rising edge, in priority order:
  1. `redirect_valid`=1: `pc`<=`redirect_pc`; `instr_valid`<=0 (flush, even if the held instruction is being accepted in the same cycle); state<=RUN.
  2. state=HALT: hold all registers.
  3. Slot free (`instr_valid`=0, or `instr_ready`=1): `instr`<=`imem_rd`; `instr_pc`<=`pc`; `instr_valid`<=1; `pc`<=`pc`+1.
  4. Otherwise (stall: `instr_valid`=1, `instr_ready`=0): hold `pc`, `instr`, and `instr_pc`.
- PC arithmetic: unsigned, PC_W bits, wraps from 2^PC_W-1 to 0 with no flag.
- Handshake: a transfer occurs when `instr_valid`&&`instr_ready` at an edge. `instr` and `instr_pc` stay stable while valid and not accepted. `instr_valid` never drops without a transfer, except on redirect or reset.
- `instr_pc_plus1` is combinational from `instr_pc`.

## Timing
- First instruction (`imem[RESET_PC]`): `instr_valid`=1 after the first rising edge following reset deassertion.
- Steady state with `instr_ready`=1: one instruction per cycle with no bubbles.
- Redirect: one bubble. Redirect at edge N; `imem[target]` is valid after edge N+1.
- Redirect during a stall: the held instruction is discarded; no transfer is counted.
- `redirect_valid` in HALT: leaves HALT; the target instruction is valid after the next edge.

## Configuration
- `FETCH_HALT_EN` defined: in step 3, if `imem_rd`==`HALT_INSTR`, the instruction is not captured. Then `instr_valid`<=0, `pc` holds at the HALT address, and state<=HALT, so `halted`=1 from the next cycle. Only a redirect or reset leaves HALT.
- `FETCH_HALT_EN` undefined: no HALT state. `HALT_INSTR` is fetched as an ordinary word, and `halted` is tied to 0.

## Structure
- Shared package `cpu19_pkg` holds:
  - `INSTR_W`=19 and `PC_W`=6 constants.
  - `HALT_INSTR`=19'h7FFFF.
  - Typedefs `instr_t` and `pc_t`.
  - The `fetch_state_e` enum {RUN, HALT}.
- No sub-module: the PC incrementer and next-PC mux are inline. `instr_pc_plus1` reuses the same increment function, defined in the package.

## Test plan
- Reset, memory words 0..3 = 19'h04862, 19'h02862, 19'h1A8A1, 19'h0A381, `instr_ready`=1 → `instr` is 19'h04862@pc0, 19'h02862@pc1, ... on consecutive cycles, with `instr_valid` continuously high.
- Stall: `instr_ready`=0 for 3 cycles while `instr`=word1 → `instr`, `instr_pc`=1, and `imem_addr`=2 all held. When ready is reasserted, word2 follows the next cycle.
- Redirect to 5 while word2 is valid and `instr_ready`=1 → `instr_valid`=0 for one cycle, then `instr`=word5 with `instr_pc`=5 and `instr_pc_plus1`=6.
- Wrap: redirect to 63, ready=1 → `instr_pc` sequence is 63, 0, 1; `instr_pc_plus1` at 63 is 0.
- `FETCH_HALT_EN`: word3=19'h7FFFF → after word2, `halted`=1, `instr_valid`=0, `imem_addr`=3 held for 10 cycles. Redirect to 0 → `halted`=0 and word0 is delivered.
- Async reset asserted mid-stream (between edges) → `instr_valid`=0 and `imem_addr`=RESET_PC immediately. After release, word0 is valid after the first edge.

Source files
------------

// File: rtl/cpu19_pkg.sv
// Shared types and constants for the 19-bit single-cycle CPU.
package cpu19_pkg;

   localparam int unsigned INSTR_W = 19;
   localparam int unsigned PC_W    = 6;

   localparam logic [INSTR_W-1:0] HALT_INSTR = 19'h7FFFF;

   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [PC_W-1:0]    pc_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // Width-agnostic incrementer; callers truncate to their PC width, which gives the wrap.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register and valid/ready handoff to decode.
// Optional HALT detection is enabled with `define FETCH_HALT_EN.
module fetch_unit
   import cpu19_pkg::*;
#(
   parameter int unsigned PC_W     = 6,
   parameter int unsigned INSTR_W  = 19,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rd,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic [PC_W-1:0]    instr_pc_plus1,
   output logic               halted
);

   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    pc_plus1;
   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    instr_pc_q;
   logic               valid_q;
   logic               slot_free;

   assign pc_plus1       = PC_W'(pc_inc(32'(pc_q)));
   assign instr_pc_plus1 = PC_W'(pc_inc(32'(instr_pc_q)));
   assign slot_free      = !valid_q || instr_ready;

   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;

`ifdef FETCH_HALT_EN
   fetch_state_e state_q;
   logic         halt_hit;

   assign halt_hit = (imem_rd == INSTR_W'(HALT_INSTR));
   assign halted   = (state_q == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= PC_W'(RESET_PC);
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         state_q    <= RUN;
      end else if (redirect_valid) begin
         // Redirect flushes the held word even if decode accepts it this cycle.
         pc_q    <= redirect_pc;
         valid_q <= 1'b0;
         state_q <= RUN;
      end else begin
         unique case (state_q)
            HALT: ;
            RUN: begin
               if (slot_free) begin
                  if (halt_hit) begin
                     // PC stays on the HALT word so a later redirect-free restart is impossible.
                     valid_q <= 1'b0;
                     state_q <= HALT;
                  end else begin
                     instr_q    <= imem_rd;
                     instr_pc_q <= pc_q;
                     valid_q    <= 1'b1;
                     pc_q       <= pc_plus1;
                  end
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end
`else
   assign halted = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= PC_W'(RESET_PC);
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect flushes the held word even if decode accepts it this cycle.
         pc_q    <= redirect_pc;
         valid_q <= 1'b0;
      end else if (slot_free) begin
         instr_q    <= imem_rd;
         instr_pc_q <= pc_q;
         valid_q    <= 1'b1;
         pc_q       <= pc_plus1;
      end
   end
`endif

endmodule
